// File: rtl/trig_rule_sched_pkg.sv
// rtl/trig_rule_sched_pkg.sv - shared source/state encodings and TMR voter
package trig_pkg;

  // Which source produced the current L1A
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_EXT   = 2'd1,
    SRC_BURST = 2'd2,
    SRC_RAN   = 2'd3
  } src_e;

  // Burst sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } burst_st_e;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Number of physical copies kept for each protected counter
  function automatic int tmr_copies(input int tmr);
    return (tmr != 0) ? 3 : 1;
  endfunction

  // Bitwise 2-of-3 vote; with a single copy all three inputs are the same
  function automatic logic [15:0] maj3(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/trig_rule_sched_if.sv
// rtl/trig_rule_sched_if.sv - request/config inputs and trigger outputs of the scheduler
interface trig_rule_sched_if;
  logic        REQ_EXT;
  logic        REQ_BURST;
  logic        REQ_RAN;
  logic [9:0]  BURST_LEN;
  logic [3:0]  MIN_GAP;
  logic [7:0]  WIN_LEN;
  logic        L1A;
  logic [1:0]  GNT_SRC;
  logic        BUSY;
  logic        BURST_DONE;
  logic [15:0] DROP_CNT;

  modport master (
    output REQ_EXT, REQ_BURST, REQ_RAN, BURST_LEN, MIN_GAP, WIN_LEN,
    input  L1A, GNT_SRC, BUSY, BURST_DONE, DROP_CNT
  );

  modport slave (
    input  REQ_EXT, REQ_BURST, REQ_RAN, BURST_LEN, MIN_GAP, WIN_LEN,
    output L1A, GNT_SRC, BUSY, BURST_DONE, DROP_CNT
  );
endinterface

// File: rtl/trig_rule_sched_win_slot.sv
// rtl/trig_rule_sched_win_slot.sv - one sliding-window slot: loadable 8-bit down-counter
module win_slot
  import trig_pkg::*;
#(
  parameter int TMR = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_len,
  output logic       o_busy
);

  localparam int NC = tmr_copies(TMR);
  localparam int I1 = (NC > 1) ? 1 : 0;
  localparam int I2 = (NC > 2) ? 2 : 0;

  logic [7:0] r_cnt [NC];
  logic [7:0] w_cnt;
  logic [7:0] w_cnt_nxt;

  assign w_cnt     = 8'(maj3(16'(r_cnt[0]), 16'(r_cnt[I1]), 16'(r_cnt[I2])));
  assign w_cnt_nxt = i_load ? i_len : ((w_cnt != 8'd0) ? (w_cnt - 8'd1) : 8'd0);
  assign o_busy    = (w_cnt != 8'd0);

  // Load on grant, otherwise count down to zero; every copy takes the voted next value
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NC; i++) begin
      if (!i_rst_n) r_cnt[i] <= 8'd0;
      else          r_cnt[i] <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/trig_rule_sched.sv
// rtl/trig_rule_sched.sv - L1A trigger arbiter with gap, sliding-window and burst rules
module trig_rule_sched
  import trig_pkg::*;
#(
  parameter int WIN_MAX = 2,
  parameter int TMR     = 0
) (
  input logic              CLK,
  input logic              RST_N,
  trig_rule_sched_if.slave io_bus
);

  localparam int NC = tmr_copies(TMR);
  localparam int I1 = (NC > 1) ? 1 : 0;
  localparam int I2 = (NC > 2) ? 2 : 0;

  burst_st_e r_state;
  burst_st_e w_state_nxt;
  logic      r_burst_d;
  logic      r_ext_pend;
  logic      r_l1a;
  src_e      r_src;

  logic [3:0]  r_gap  [NC];
  logic [9:0]  r_rem  [NC];
  logic [15:0] r_drop [NC];
  logic [3:0]  w_gap, w_gap_nxt;
  logic [9:0]  w_rem, w_rem_nxt;
  logic [15:0] w_drop, w_drop_nxt;

  logic               w_allow, w_grant, w_found;
  logic               w_ext_req, w_burst_req, w_ran_req, w_burst_rise;
  src_e               w_src;
  logic [WIN_MAX-1:0] w_slot_busy, w_slot_load;
  logic [7:0]         w_nbusy;
  logic [7:0]         w_win_len;

  assign w_gap  = 4'(maj3(16'(r_gap[0]), 16'(r_gap[I1]), 16'(r_gap[I2])));
  assign w_rem  = 10'(maj3(16'(r_rem[0]), 16'(r_rem[I1]), 16'(r_rem[I2])));
  assign w_drop = maj3(r_drop[0], r_drop[I1], r_drop[I2]);

  // The grant cycle counts as the first window cycle, so the slot holds WIN_LEN-1 after it
  assign w_win_len = io_bus.WIN_LEN - 8'd1;

  for (genvar g = 0; g < WIN_MAX; g++) begin : g_slot
    win_slot #(.TMR(TMR)) u_slot (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_load  (w_slot_load[g]),
      .i_len   (w_win_len),
      .o_busy  (w_slot_busy[g])
    );
  end

  // Count occupied window slots
  always_comb begin
    w_nbusy = 8'd0;
    for (int i = 0; i < WIN_MAX; i++) w_nbusy = w_nbusy + {7'd0, w_slot_busy[i]};
  end

  assign w_allow      = (w_gap == 4'd0) && (w_nbusy < 8'(WIN_MAX));
  assign w_ext_req    = r_ext_pend | io_bus.REQ_EXT;
  assign w_burst_req  = (r_state == ST_RUN) && io_bus.REQ_BURST && (w_rem != 10'd0);
  assign w_ran_req    = io_bus.REQ_RAN && (r_state != ST_RUN);
  assign w_burst_rise = io_bus.REQ_BURST && !r_burst_d;

  // Fixed-priority arbitration EXT > BURST > RAN, gated by the gap and window rules
  always_comb begin
    w_src = SRC_NONE;
    if (w_allow) begin
      if (w_ext_req)        w_src = SRC_EXT;
      else if (w_burst_req) w_src = SRC_BURST;
      else if (w_ran_req)   w_src = SRC_RAN;
    end
  end

  assign w_grant = (w_src != SRC_NONE);

  // Each grant claims the lowest free slot unless the window rule is disabled
  always_comb begin
    w_slot_load = '0;
    w_found     = 1'b0;
    for (int i = 0; i < WIN_MAX; i++) begin
      if (w_grant && (io_bus.WIN_LEN != 8'd0) && !w_slot_busy[i] && !w_found) begin
        w_slot_load[i] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign w_gap_nxt  = w_grant ? io_bus.MIN_GAP
                              : ((w_gap != 4'd0) ? (w_gap - 4'd1) : 4'd0);
  assign w_drop_nxt = (io_bus.REQ_RAN && (w_src != SRC_RAN) && (w_drop != DROP_MAX))
                      ? (w_drop + 16'd1) : w_drop;

  // Burst sequencer next state and remaining-count update
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = w_rem;
    case (r_state)
      ST_IDLE: begin
        if (w_burst_rise) begin
          w_state_nxt = ST_RUN;
          w_rem_nxt   = io_bus.BURST_LEN;
        end
      end
      ST_RUN: begin
        if (!io_bus.REQ_BURST)        w_state_nxt = ST_IDLE;
        else if (w_rem == 10'd0)      w_state_nxt = ST_DONE;
        else if (w_src == SRC_BURST)  w_rem_nxt   = w_rem - 10'd1;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control state and the registered L1A/source outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_burst_d  <= 1'b0;
      r_ext_pend <= 1'b0;
      r_l1a      <= 1'b0;
      r_src      <= SRC_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_burst_d  <= io_bus.REQ_BURST;
      r_ext_pend <= w_ext_req && (w_src != SRC_EXT);
      r_l1a      <= w_grant;
      r_src      <= w_src;
    end
  end

  // Gap, burst-remaining and drop counters, one copy per TMR lane
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NC; i++) begin
      if (!RST_N) begin
        r_gap[i]  <= 4'd0;
        r_rem[i]  <= 10'd0;
        r_drop[i] <= 16'd0;
      end else begin
        r_gap[i]  <= w_gap_nxt;
        r_rem[i]  <= w_rem_nxt;
        r_drop[i] <= w_drop_nxt;
      end
    end
  end

  assign io_bus.L1A        = r_l1a;
  assign io_bus.GNT_SRC    = r_src;
  assign io_bus.BUSY       = (r_state == ST_RUN);
  assign io_bus.BURST_DONE = (r_state == ST_DONE);
  assign io_bus.DROP_CNT   = w_drop;

endmodule
